// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
//
// Time-multiplexed driver for six 7-segment digits that share one segment bus.
// Each digit gets a slot of DIV cycles. The first BLANK_CYCLES cycles of every
// slot hold all outputs inactive, which suppresses ghosting between digits.
// A frame is six slots. At the start of each frame the six input codes are
// copied into a snapshot, so a single frame never mixes old and new time.
// Digits selected by blink_mask are blanked during alternate groups of
// BLINK_FRAMES frames. Their digit enable stays active while blanked.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-low reset
//   sec_ones_seg  digit 0 segment code (bit0 = a .. bit6 = g, 1 = lit)
//   sec_tens_seg  digit 1 segment code
//   min_ones_seg  digit 2 segment code
//   min_tens_seg  digit 3 segment code
//   hr_ones_seg   digit 4 segment code
//   hr_tens_seg   digit 5 segment code
//   blink_mask    bit i = 1 makes digit i blink (sampled live)
//   seg_out       shared segment bus, polarity set by SEG_ACTIVE_LOW
//   dig_en        one-hot digit select, polarity set by DIG_ACTIVE_LOW
//   frame_start   one-cycle pulse in the cycle after each snapshot is taken
// -----------------------------------------------------------------------------
module seven_seg_scanner #(
    parameter int DIV            = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int BLINK_FRAMES   = 42,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] sec_ones_seg,
    input  logic [6:0] sec_tens_seg,
    input  logic [6:0] min_ones_seg,
    input  logic [6:0] min_tens_seg,
    input  logic [6:0] hr_ones_seg,
    input  logic [6:0] hr_tens_seg,
    input  logic [5:0] blink_mask,
    output logic [6:0] seg_out,
    output logic [5:0] dig_en,
    output logic       frame_start
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(BLINK_FRAMES - 1);

    // Inactive output levels; XOR with these converts lit/selected to the pin polarity.
    localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [5:0] DIG_OFF = {6{DIG_ACTIVE_LOW}};

    // Scan state
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;

    // Blink state
    logic [FC_W-1:0]  fc_q, fc_d;
    logic             phase_q, phase_d;
    logic             armed_q, armed_d;

    // Frame snapshot, element i = digit i, stored in lit-high form
    logic [5:0][6:0]  snap_q, snap_d;

    // Registered outputs
    logic [6:0]       seg_q, seg_d;
    logic [5:0]       dig_q, dig_d;
    logic             fs_q, fs_d;

    logic             frame_edge;
    logic             blank;
    logic             blinked;
    logic [6:0]       seg_act;
    logic [5:0]       dig_act;

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        fc_d    = fc_q;
        phase_d = phase_q;
        armed_d = armed_q;
        snap_d  = snap_q;

        frame_edge = (cnt_q == '0) && (idx_q == 3'd0);

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end

        if (frame_edge) begin
            snap_d = {hr_tens_seg, hr_ones_seg, min_tens_seg,
                      min_ones_seg, sec_tens_seg, sec_ones_seg};
            // The first snapshot after reset opens frame 0 and does not advance
            // the counter, so the counter always equals the frame number modulo
            // BLINK_FRAMES and the first blanked group starts at frame
            // BLINK_FRAMES.
            armed_d = 1'b1;
            if (armed_q) begin
                if (fc_q == FC_LAST) begin
                    fc_d    = '0;
                    phase_d = ~phase_q;
                end else begin
                    fc_d = fc_q + 1'b1;
                end
            end
        end

        blank   = (cnt_q < BLANK_END);
        blinked = phase_q && blink_mask[idx_q];
        dig_act = blank ? 6'b0 : (6'b1 << idx_q);
        seg_act = (blank || blinked) ? 7'b0 : snap_q[idx_q];

        seg_d = seg_act ^ SEG_OFF;
        dig_d = dig_act ^ DIG_OFF;
        fs_d  = frame_edge;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            fc_q    <= '0;
            phase_q <= 1'b0;
            armed_q <= 1'b0;
            snap_q  <= '0;
            seg_q   <= SEG_OFF;
            dig_q   <= DIG_OFF;
            fs_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            fc_q    <= fc_d;
            phase_q <= phase_d;
            armed_q <= armed_d;
            snap_q  <= snap_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            fs_q    <= fs_d;
        end
    end

    assign seg_out     = seg_q;
    assign dig_en      = dig_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner. Two instances share all inputs:
// u_lo uses active-low polarity, u_hi active-high, so both polarities are
// checked on the same timeline. Expected outputs are derived from t, the
// number of clock edges since reset release (cnt = t%8, idx = (t/8)%6,
// frame = t/48), and from the inputs present at each frame's first edge.
module tb_seven_seg_scanner;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int BF    = 2;
    localparam int FRAME = 6 * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] s0, s1, m0, m1, h0, h1;
    logic [5:0] mask;
    logic [6:0] seg_lo, seg_hi;
    logic [5:0] dig_lo, dig_hi;
    logic       fs_lo, fs_hi;

    int         tests = 0;
    int         fails = 0;
    int         t;
    logic [6:0] snap [6];

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .DIV(DIV), .BLANK_CYCLES(BLANK), .BLINK_FRAMES(BF),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) u_lo (
        .clk(clk), .reset(reset),
        .sec_ones_seg(s0), .sec_tens_seg(s1),
        .min_ones_seg(m0), .min_tens_seg(m1),
        .hr_ones_seg(h0), .hr_tens_seg(h1),
        .blink_mask(mask),
        .seg_out(seg_lo), .dig_en(dig_lo), .frame_start(fs_lo)
    );

    seven_seg_scanner #(
        .DIV(DIV), .BLANK_CYCLES(BLANK), .BLINK_FRAMES(BF),
        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) u_hi (
        .clk(clk), .reset(reset),
        .sec_ones_seg(s0), .sec_tens_seg(s1),
        .min_ones_seg(m0), .min_tens_seg(m1),
        .hr_ones_seg(h0), .hr_tens_seg(h1),
        .blink_mask(mask),
        .seg_out(seg_hi), .dig_en(dig_hi), .frame_start(fs_hi)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    function automatic int popc6(input logic [5:0] v);
        int n = 0;
        for (int i = 0; i < 6; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic check_inactive(input string tag);
        chk({tag, "_seg_lo"}, {1'b0, seg_lo}, 8'h7F);
        chk({tag, "_dig_lo"}, {2'b0, dig_lo}, 8'h3F);
        chk({tag, "_fs_lo"},  {7'b0, fs_lo},  8'h00);
        chk({tag, "_seg_hi"}, {1'b0, seg_hi}, 8'h00);
        chk({tag, "_dig_hi"}, {2'b0, dig_hi}, 8'h00);
        chk({tag, "_fs_hi"},  {7'b0, fs_hi},  8'h00);
    endtask

    task automatic check_cycle();
        int         cnt   = t % DIV;
        int         idx   = (t / DIV) % 6;
        int         f     = t / FRAME;
        logic       blink = mask[idx] && (((f / BF) % 2) == 1);
        logic [5:0] dact  = (cnt >= BLANK) ? (6'b1 << idx) : 6'b0;
        logic [6:0] sact  = (cnt >= BLANK && !blink) ? snap[idx] : 7'b0;
        logic       fsx   = (cnt == 0) && (idx == 0);
        chk("seg_lo", {1'b0, seg_lo}, {1'b0, ~sact});
        chk("dig_lo", {2'b0, dig_lo}, {2'b0, ~dact});
        chk("fs_lo",  {7'b0, fs_lo},  {7'b0, fsx});
        chk("seg_hi", {1'b0, seg_hi}, {1'b0, sact});
        chk("dig_hi", {2'b0, dig_hi}, {2'b0, dact});
        chk("fs_hi",  {7'b0, fs_hi},  {7'b0, fsx});
        chk("onehot_lo", {7'b0, popc6(~dig_lo) <= 1}, 8'd1);
        chk("onehot_hi", {7'b0, popc6(dig_hi) <= 1}, 8'd1);
        chk("ghost_lo", {7'b0, (~dig_lo == 6'b0) && (~seg_lo != 7'b0)}, 8'd0);
        chk("ghost_hi", {7'b0, (dig_hi == 6'b0) && (seg_hi != 7'b0)}, 8'd0);
    endtask

    // Advance one clock edge, recording the snapshot the DUT should capture
    // when that edge opens a frame, then check the registered outputs.
    task automatic step();
        t++;
        if (t % FRAME == 0) begin
            snap[0] = s0; snap[1] = s1; snap[2] = m0;
            snap[3] = m1; snap[4] = h0; snap[5] = h1;
        end
        @(posedge clk);
        @(negedge clk);
        check_cycle();
    endtask

    initial begin
        s0 = 7'h01; s1 = 7'h02; m0 = 7'h04; m1 = 7'h08; h0 = 7'h10; h1 = 7'h20;
        mask = 6'b000000;
        for (int i = 0; i < 6; i++) snap[i] = 7'h00;
        t = -1;

        // Held in reset: everything inactive
        repeat (3) @(negedge clk);
        check_inactive("reset");

        // Frame 0: digit i shows 7'h01<<i
        reset = 1'b1;
        repeat (FRAME) step();

        // Frame 1 snapshots 3F; the change to 06 in slot 3 must wait for frame 2
        s0 = 7'h3F;
        repeat (3 * DIV + 3) step();
        s0 = 7'h06;
        repeat (3 * DIV - 3) step();

        // Frame 2 shows 06 on digit 0; run into frame 3, digit 3 active (t=172)
        repeat (172 - (2 * FRAME - 1)) step();
        chk("pre_rst_dig_lo", {2'b0, dig_lo}, 8'h37);
        chk("pre_rst_dig_hi", {2'b0, dig_hi}, 8'h08);

        // Asynchronous reset between edges
        reset = 1'b0;
        #1;
        check_inactive("async_rst");
        repeat (2) @(negedge clk);
        check_inactive("rst_hold");

        // Restart with blinking on digits 0-1; ten frames of full checks
        s0 = 7'h01;
        mask = 6'b000011;
        t = -1;
        reset = 1'b1;
        repeat (10 * FRAME) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
